inst_loader: RTL

//  Boot-time program loader upstream of the 5-stage RISC_V core. Receives a byte

---
 rtl/inst_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// inst_loader
//   Boot-time program loader sitting in front of the RISC-V core. A byte stream
//   arrives over a valid/ready handshake in the form
//     N (4 bytes) | N instruction words (4 bytes each) | checksum (4 bytes)
//   with every field little-endian. Words are assembled and written one per
//   WRITE cycle into instruction memory. The core is held in reset until a load
//   finishes with a matching checksum (32-bit wrapping sum of all words).
//
// Ports
//   clk, reset            clock (rising edge) / asynchronous active-high reset
//   start                 one-cycle request for a new load (ignored while busy)
//   rx_valid, rx_data     incoming byte stream
//   rx_ready              loader takes a byte this cycle (LEN, DATA, CSUM)
//   imem_we/addr/wdata    instruction-memory write port (one-cycle strobe)
//   core_reset            1 = core held in reset
//   busy, done, error     load status
//   words_loaded          words written in the current/last load
module inst_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR
  } state_t;

  localparam logic [31:0]     MAX_N   = MAX_WORDS;
  localparam logic [ADDR_W:0] IDX_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_next;
  logic [1:0]        byte_cnt;
  logic [31:0]       shift;
  logic [ADDR_W:0]   index;
  logic [ADDR_W:0]   n_words;
  logic [31:0]       sum;

  logic              take;
  logic              last_byte;
  logic              load;
  logic [31:0]       field;

  assign take      = rx_valid & rx_ready;
  assign last_byte = take && (byte_cnt == 2'd3);
  assign load      = start && (state == IDLE || state == DONE || state == ERROR);
  // Bytes shift in from the top, so after four bytes the first one sits in [7:0].
  // On the 4th byte this is the complete little-endian field.
  assign field     = {rx_data, shift[31:8]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE, ERROR: if (start) state_next = LEN;
      LEN: if (last_byte) begin
        if (field > MAX_N)       state_next = ERROR;
        else if (field == 32'd0) state_next = CSUM;
        else                     state_next = DATA;
      end
      DATA:  if (last_byte) state_next = WRITE;
      // index still holds the pre-increment value during WRITE
      WRITE: state_next = ((index + IDX_ONE) == n_words) ? CSUM : DATA;
      CSUM: if (last_byte) state_next = (field == sum) ? DONE : ERROR;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    rx_ready   = (state == LEN) || (state == DATA) || (state == CSUM);
    busy       = rx_ready || (state == WRITE);
    imem_we    = (state == WRITE);
    done       = (state == DONE);
    error      = (state == ERROR);
    core_reset = (state != DONE);
  end

  // Datapath: byte assembly, word index, checksum accumulator, write port.
  // imem_addr/imem_wdata are loaded on the edge entering WRITE so they are valid
  // during the strobe and simply hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= '0;
      shift      <= '0;
      index      <= '0;
      n_words    <= '0;
      sum        <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      if (load) begin
        byte_cnt <= '0;
        index    <= '0;
        n_words  <= '0;
        sum      <= '0;
      end
      if (take) begin
        byte_cnt <= byte_cnt + 2'd1;
        shift    <= field;
      end
      // Only a length <= MAX_WORDS ever leads anywhere but ERROR, so the
      // truncation to ADDR_W+1 bits is lossless on every path that uses it.
      if (state == LEN && last_byte) n_words <= field[ADDR_W:0];
      if (state == DATA && last_byte) begin
        imem_addr  <= index[ADDR_W-1:0];
        imem_wdata <= field;
      end
      if (state == WRITE) begin
        index <= index + IDX_ONE;
        sum   <= sum + imem_wdata;
      end
    end
  end

  assign words_loaded = index;

endmodule
